bus_arbiter_n: RTL and testbench

- Parametrised shared-bus arbiter and address decoder. Successor to the fixed top-level mux of data bus, instruction bus and debug unit.
- Arbitrates N masters onto one bus. Master 0 (debug unit) may have fixed priority; the remaining masters are served round-robin.
- Decodes a slave index from the address, waits for a per-slave acknowledge, and returns a registered single-cycle response.
- Adds a timeout/error path and an unmapped-address error path that the old design lacks.

---
 rtl/bus_arbiter_n.sv | 199 +++++++++++++++++++
 tb/tb_bus_arbiter_n.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_n.sv
// Shared-bus arbiter and slave address decoder for N masters.
// Ports: clk, reset (async, active high); m_* master side (packed
//   per master); s_* slave side (packed per slave); gnt_idx = owner.
module bus_arbiter_n #(
  parameter int N_MASTERS = 3,
  parameter int N_SLAVES  = 3,
  parameter int ADR_W     = 32,
  parameter int DATA_W    = 32,
  parameter int SEL_LSB   = 16,
  parameter int SEL_W     = 2,
  parameter int PRIO0     = 1,
  parameter int TIMEOUT   = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_MASTERS-1:0]          m_req,
  input  logic [N_MASTERS*ADR_W-1:0]    m_adr,
  input  logic [N_MASTERS*DATA_W/8-1:0] m_wren,
  input  logic [N_MASTERS*DATA_W-1:0]   m_di,
  output logic [N_MASTERS-1:0]          m_rdy,
  output logic [N_MASTERS-1:0]          m_err,
  output logic [DATA_W-1:0]             m_do,
  output logic [N_SLAVES-1:0]           s_sel,
  output logic [ADR_W-1:0]              s_adr,
  output logic [DATA_W/8-1:0]           s_wren,
  output logic [DATA_W-1:0]             s_di,
  input  logic [N_SLAVES*DATA_W-1:0]    s_do,
  input  logic [N_SLAVES-1:0]           s_ack,
  output logic [2:0]                    gnt_idx
);

  localparam int WE_W  = DATA_W / 8;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [SEL_W:0]   NS      = (SEL_W + 1)'(N_SLAVES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         gnt_q, gnt_d;
  logic [2:0]         rr_q, rr_d;
  logic [SEL_W-1:0]   slv_q, slv_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [DATA_W-1:0]  do_q, do_d;

  logic [N_MASTERS-1:0] req_rr;
  logic               win_vld;
  logic               prio_win;
  logic [2:0]         win_idx;
  logic [SEL_W-1:0]   win_slv;
  logic               unmapped;
  logic               ack_hit;
  logic [DATA_W-1:0]  ack_data;
  int                 cand;

  // Master 0 is excluded from the rotation when it has fixed priority.
  always_comb begin
    req_rr = m_req;
    if (PRIO0 != 0) req_rr[0] = 1'b0;
  end

  always_comb begin
    win_vld  = 1'b0;
    prio_win = 1'b0;
    win_idx  = 3'd0;
    cand     = 0;
    if (PRIO0 != 0 && m_req[0]) begin
      win_vld  = 1'b1;
      prio_win = 1'b1;
    end else begin
      for (int k = 1; k <= N_MASTERS; k++) begin
        cand = (int'(rr_q) + k) % N_MASTERS;
        if (!win_vld &&
            |(req_rr & (N_MASTERS'(1) << cand))) begin
          win_vld = 1'b1;
          win_idx = 3'(cand);
        end
      end
    end
  end

  always_comb begin
    win_slv = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (win_idx == 3'(i))
        win_slv = m_adr[i*ADR_W+SEL_LSB +: SEL_W];
    end
    unmapped = ({1'b0, win_slv} >= NS);
  end

  // Slave side follows the granted master combinationally.
  always_comb begin
    s_adr  = '0;
    s_wren = '0;
    s_di   = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (gnt_q == 3'(i)) begin
        s_adr  = m_adr[i*ADR_W +: ADR_W];
        s_wren = m_wren[i*WE_W +: WE_W];
        s_di   = m_di[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    s_sel    = '0;
    ack_hit  = 1'b0;
    ack_data = '0;
    for (int s = 0; s < N_SLAVES; s++) begin
      if (state_q == ACCESS && slv_q == SEL_W'(s)) begin
        s_sel[s] = 1'b1;
        ack_hit  = s_ack[s];
        ack_data = s_do[s*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    m_rdy = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (state_q == RESP && gnt_q == 3'(i))
        m_rdy[i] = 1'b1;
    end
    m_err = m_rdy & {N_MASTERS{err_q}};
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    slv_d   = slv_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    do_d    = do_q;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          gnt_d = win_idx;
          if (!prio_win) rr_d = win_idx;
          slv_d = win_slv;
          cnt_d = '0;
          if (unmapped) begin
            err_d   = 1'b1;
            do_d    = '0;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        // An ack in the timeout cycle still counts as success.
        if (ack_hit) begin
          do_d    = ack_data;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
          do_d    = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= 3'd0;
      rr_q    <= 3'd0;
      slv_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      do_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      slv_q   <= slv_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      do_q    <= do_d;
    end
  end

  assign m_do    = do_q;
  assign gnt_idx = gnt_q;

endmodule

// File: tb/tb_bus_arbiter_n.sv
// Directed testbench for bus_arbiter_n (3 masters, 3 slaves,
// TIMEOUT=4, master 0 fixed priority).
module tb_bus_arbiter_n;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  m_req = '0;
  logic [95:0] m_adr = '0;
  logic [11:0] m_wren = '0;
  logic [95:0] m_di = '0;
  logic [2:0]  m_rdy;
  logic [2:0]  m_err;
  logic [31:0] m_do;
  logic [2:0]  s_sel;
  logic [31:0] s_adr;
  logic [3:0]  s_wren;
  logic [31:0] s_di;
  logic [95:0] s_do = '0;
  logic [2:0]  s_ack = '0;
  logic [2:0]  gnt_idx;

  int n_chk = 0;
  int n_fail = 0;

  bus_arbiter_n #(
    .N_MASTERS(3), .N_SLAVES(3), .ADR_W(32), .DATA_W(32),
    .SEL_LSB(16), .SEL_W(2), .PRIO0(1), .TIMEOUT(4)
  ) dut (
    .clk(clk), .reset(reset),
    .m_req(m_req), .m_adr(m_adr), .m_wren(m_wren), .m_di(m_di),
    .m_rdy(m_rdy), .m_err(m_err), .m_do(m_do),
    .s_sel(s_sel), .s_adr(s_adr), .s_wren(s_wren), .s_di(s_di),
    .s_do(s_do), .s_ack(s_ack), .gnt_idx(gnt_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int i, input logic [31:0] adr,
                       input logic [3:0] we, input logic [31:0] di);
    m_adr[i*32 +: 32] = adr;
    m_wren[i*4 +: 4]  = we;
    m_di[i*32 +: 32]  = di;
  endtask

  int exp_g [5] = '{0, 1, 2, 1, 2};
  int n;

  initial begin
    #1;
    chk("rst_rdy", 32'(m_rdy), 0);
    chk("rst_err", 32'(m_err), 0);
    chk("rst_sel", 32'(s_sel), 0);
    chk("rst_do", m_do, 0);
    chk("rst_gnt", 32'(gnt_idx), 0);
    tick();
    tick();
    reset = 1'b0;

    // 1: read from slave 1, ack in 2nd ACCESS cycle
    set_m(1, 32'h0001_0010, 4'h0, 32'h0);
    m_req = 3'b010;
    tick();
    chk("rd_sel1", 32'(s_sel), 32'b010);
    chk("rd_gnt", 32'(gnt_idx), 1);
    chk("rd_rdy_early", 32'(m_rdy), 0);
    chk("rd_adr", s_adr, 32'h0001_0010);
    tick();
    chk("rd_sel2", 32'(s_sel), 32'b010);
    s_do[32 +: 32] = 32'hDEAD_BEEF;
    s_ack = 3'b010;
    tick();
    s_ack = '0;
    chk("rd_rdy", 32'(m_rdy), 32'b010);
    chk("rd_do", m_do, 32'hDEAD_BEEF);
    chk("rd_err", 32'(m_err), 0);
    chk("rd_sel_resp", 32'(s_sel), 0);
    m_req = '0;
    tick();
    chk("rd_rdy_pulse", 32'(m_rdy), 0);
    chk("rd_do_hold", m_do, 32'hDEAD_BEEF);

    // 3: write from master 2 to slave 0, immediate ack
    set_m(2, 32'h0000_0004, 4'b0011, 32'h1234_5678);
    m_req = 3'b100;
    tick();
    chk("wr_sel", 32'(s_sel), 32'b001);
    chk("wr_adr", s_adr, 32'h4);
    chk("wr_wren", 32'(s_wren), 32'b0011);
    chk("wr_di", s_di, 32'h1234_5678);
    s_do[0 +: 32] = 32'h0;
    s_ack = 3'b001;
    tick();
    s_ack = '0;
    chk("wr_rdy", 32'(m_rdy), 32'b100);
    chk("wr_err", 32'(m_err), 0);
    m_req = '0;
    tick();

    // 2: fixed priority plus round-robin
    set_m(0, 32'h0, 4'h0, 32'h0);
    set_m(1, 32'h0, 4'h0, 32'h0);
    set_m(2, 32'h0, 4'h0, 32'h0);
    s_do[0 +: 32] = 32'h0000_00AA;
    s_ack = 3'b111;
    m_req = 3'b111;
    for (int g = 0; g < 5; g++) begin
      n = 0;
      while (m_rdy == 0 && n < 10) begin
        tick();
        n++;
      end
      chk("rr_rdy", 32'(m_rdy), 32'(1 << exp_g[g]));
      chk("rr_gnt", 32'(gnt_idx), 32'(exp_g[g]));
      if (g == 0) m_req[0] = 1'b0;
      if (g == 4) m_req = '0;
      tick();
    end
    s_ack = '0;
    tick();

    // 4a: unmapped address -> error, no select
    set_m(1, 32'h0003_0000, 4'h0, 32'h0);
    m_req = 3'b010;
    tick();
    chk("um_sel", 32'(s_sel), 0);
    chk("um_rdy", 32'(m_rdy), 32'b010);
    chk("um_err", 32'(m_err), 32'b010);
    chk("um_do", m_do, 0);
    m_req = '0;
    tick();
    chk("um_after", 32'(m_rdy), 0);

    // 4b: timeout, with a stray ack from a non-selected slave
    set_m(1, 32'h0000_0000, 4'h0, 32'h0);
    m_req = 3'b010;
    s_ack = 3'b010;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("to_sel", 32'(s_sel), 32'b001);
      chk("to_rdy_early", 32'(m_rdy), 0);
    end
    tick();
    s_ack = '0;
    chk("to_rdy", 32'(m_rdy), 32'b010);
    chk("to_err", 32'(m_err), 32'b010);
    chk("to_do", m_do, 0);
    m_req = '0;
    tick();

    // 6: ack in the same cycle the timeout would fire
    set_m(2, 32'h0000_0008, 4'h0, 32'h0);
    s_do[0 +: 32] = 32'hCAFE_F00D;
    m_req = 3'b100;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("sc_sel", 32'(s_sel), 32'b001);
    end
    s_ack = 3'b001;
    tick();
    s_ack = '0;
    chk("sc_rdy", 32'(m_rdy), 32'b100);
    chk("sc_err", 32'(m_err), 0);
    chk("sc_do", m_do, 32'hCAFE_F00D);
    m_req = '0;
    tick();

    // 5: reset in the first ACCESS cycle
    set_m(1, 32'h0002_0000, 4'h0, 32'h0);
    m_req = 3'b010;
    tick();
    chk("rs_gnt_pre", 32'(gnt_idx), 1);
    chk("rs_sel_pre", 32'(s_sel), 32'b100);
    #1 reset = 1'b1;
    #1;
    chk("rs_sel_async", 32'(s_sel), 0);
    chk("rs_rdy_async", 32'(m_rdy), 0);
    m_req = '0;
    tick();
    tick();
    chk("rs_rdy_hold", 32'(m_rdy), 0);
    reset = 1'b0;
    chk("rs_gnt", 32'(gnt_idx), 0);
    set_m(2, 32'h0002_0000, 4'h0, 32'h0);
    m_req = 3'b110;
    tick();
    chk("rs_rr_gnt", 32'(gnt_idx), 1);
    s_do[64 +: 32] = 32'h0000_55AA;
    s_ack = 3'b100;
    tick();
    s_ack = '0;
    chk("rs_rdy", 32'(m_rdy), 32'b010);
    chk("rs_do", m_do, 32'h0000_55AA);
    m_req = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
